sampler_mc: RTL and testbench

//  Multi-channel successor of the single-channel gated sampler. Captures NUM_CH ADC channels in parallel while the

---
 rtl/sampler_mc_if.sv | 48 ++++
 rtl/sampler_mc.sv | 254 +++++++++++++++++++++++++
 tb/tb_sampler_mc.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_mc_if.sv
// ============================================================================
// Module      : sampler_mc_if
// Description : Bundle of the control, ADC capture and drain-stream signals
//               of the multi-channel gated sampler.
//               master modport: the side that drives enable/start/gate/data,
//                               the commands and i_ready (front-end/readout).
//               slave modport : the sampler itself.
// Signals     : i_enable, i_start, i_gate, i_data[NUM_CH*DATA_SIZE],
//               i_cmd_decim, i_cmd_mode, i_cmd_param[DATA_SIZE], i_ready,
//               o_data[DATA_SIZE], o_channel[CH_W], o_valid, o_last, o_idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sampler_mc_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_CH    = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                        i_enable;
    logic                        i_start;
    logic                        i_gate;
    logic [NUM_CH*DATA_SIZE-1:0] i_data;
    logic                        i_cmd_decim;
    logic                        i_cmd_mode;
    logic [DATA_SIZE-1:0]        i_cmd_param;
    logic [DATA_SIZE-1:0]        o_data;
    logic [CH_W-1:0]             o_channel;
    logic                        o_valid;
    logic                        i_ready;
    logic                        o_last;
    logic                        o_idle;

    modport master (
        output i_enable, i_start, i_gate, i_data,
        output i_cmd_decim, i_cmd_mode, i_cmd_param, i_ready,
        input  o_data, o_channel, o_valid, o_last, o_idle
    );

    modport slave (
        input  i_enable, i_start, i_gate, i_data,
        input  i_cmd_decim, i_cmd_mode, i_cmd_param, i_ready,
        output o_data, o_channel, o_valid, o_last, o_idle
    );
endinterface

`default_nettype wire

// File: rtl/sampler_mc.sv
// ============================================================================
// Module      : sampler_mc
// Description : Multi-channel gated sampler. Captures NUM_CH channels in
//               parallel while the gate is high, decimates each channel
//               (pick-last or unsigned peak-hold), stores DEPTH frames and
//               drains them channel-interleaved over a valid/ready stream.
// Ports       : i_clock    - clock, rising edge
//               i_reset_n  - asynchronous active-low reset
//               bus        - sampler_mc_if.slave (control, ADC data,
//                            commands, drain stream, idle flag)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sampler_mc #(
    parameter int DATA_SIZE     = 8,
    parameter int NUM_CH        = 2,
    parameter int DEPTH         = 1024,
    parameter int ADDR_SIZE     = 10,
    parameter int DECIM_DEFAULT = 4
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    sampler_mc_if.slave  bus
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FRAME_W = NUM_CH * DATA_SIZE;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // configuration
    logic [DATA_SIZE-1:0] decim;
    logic [DATA_SIZE-1:0] decim_eff;
    logic                 mode;

    // capture path
    logic                                gate_r;
    logic                                gate_last;
    logic [NUM_CH-1:0][DATA_SIZE-1:0]    data_r;
    logic [NUM_CH-1:0][DATA_SIZE-1:0]    acc;
    logic [NUM_CH-1:0][DATA_SIZE-1:0]    frame_val;
    logic [DATA_SIZE-1:0]                cnt;
    logic [ADDR_SIZE-1:0]                wr_addr;
    logic                                gate_edge;
    logic                                sample_en;
    logic                                window_end;
    logic                                last_frame;

    // frame buffer
    logic [FRAME_W-1:0]                  mem [DEPTH];
    logic [FRAME_W-1:0]                  rd_word;
    logic [NUM_CH-1:0][DATA_SIZE-1:0]    rd_frame;

    // drain path
    logic [ADDR_SIZE-1:0]                rd_addr;
    logic [CH_W-1:0]                     ch;
    logic                                fetched;
    logic                                handshake;
    logic                                load_slot;
    logic                                out_valid;
    logic                                out_last;
    logic [DATA_SIZE-1:0]                out_data;
    logic [CH_W-1:0]                     out_channel;

    assign decim_eff  = (decim == '0) ? DATA_SIZE'(1) : decim;
    // gate and data are registered together, so the edge cycle carries the
    // first sample of the window and is counted like any other gated cycle
    assign gate_edge  = gate_r & ~gate_last;
    assign sample_en  = bus.i_enable &&
                        (((state == S_ARMED) && gate_edge) ||
                         ((state == S_CAPTURE) && gate_r));
    assign window_end = (cnt == (decim_eff - DATA_SIZE'(1)));
    assign last_frame = (wr_addr == ADDR_SIZE'(DEPTH - 1));
    assign handshake  = out_valid & bus.i_ready;
    assign rd_frame   = rd_word;

    // ------------------------------------------------------------------
    // state machine
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (sample_en) begin
                    state_next = (window_end && last_frame) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!gate_r) begin
                    state_next = S_ARMED;
                end else if (window_end && last_frame) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (handshake && out_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (!bus.i_enable) begin
            state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // configuration: commands only take effect in IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            decim <= DATA_SIZE'(DECIM_DEFAULT);
            mode  <= 1'b0;
        end else if (state == S_IDLE) begin
            if (bus.i_cmd_decim) begin
                decim <= bus.i_cmd_param;
            end
            if (bus.i_cmd_mode) begin
                mode <= bus.i_cmd_param[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // decimation: first sample of a window (cnt==0) always reloads the
    // accumulator; in peak mode later samples keep the unsigned maximum
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            frame_val[k] = data_r[k];
            if (mode && (cnt != '0) && (acc[k] > data_r[k])) begin
                frame_val[k] = acc[k];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gate_r    <= 1'b0;
            gate_last <= 1'b0;
            data_r    <= '0;
            acc       <= '0;
            cnt       <= '0;
            wr_addr   <= '0;
        end else begin
            gate_r    <= bus.i_gate;
            gate_last <= gate_r;
            data_r    <= bus.i_data;
            if (state == S_IDLE) begin
                cnt     <= '0;
                wr_addr <= '0;
            end else if ((state == S_CAPTURE) && !gate_r) begin
                // partial window is dropped; wr_addr is kept so the next
                // complete frame lands right after the last stored one
                cnt <= '0;
            end else if (sample_en) begin
                acc <= frame_val;
                if (window_end) begin
                    cnt     <= '0;
                    wr_addr <= wr_addr + ADDR_SIZE'(1);
                end else begin
                    cnt <= cnt + DATA_SIZE'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // frame buffer, synchronous read
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (sample_en && window_end) begin
            mem[wr_addr] <= frame_val;
        end
        rd_word <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // drain: rd_word holds frame rd_addr once fetched is set. The read
    // address advances as soon as the last channel of a frame is loaded
    // into the output register, so the next fetch overlaps the consumer
    // accepting that sample.
    // ------------------------------------------------------------------
    assign load_slot = (!out_valid) || handshake;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            rd_addr     <= '0;
            ch          <= '0;
            fetched     <= 1'b0;
        end else if ((state != S_DRAIN) || (state_next != S_DRAIN)) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_addr   <= '0;
            ch        <= '0;
            fetched   <= 1'b0;
        end else begin
            fetched <= 1'b1;
            if (load_slot) begin
                if (fetched) begin
                    out_valid   <= 1'b1;
                    out_data    <= rd_frame[ch];
                    out_channel <= ch;
                    out_last    <= (rd_addr == ADDR_SIZE'(DEPTH - 1)) &&
                                   (ch == CH_W'(NUM_CH - 1));
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        ch      <= '0;
                        rd_addr <= rd_addr + ADDR_SIZE'(1);
                        fetched <= 1'b0;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.o_valid   = out_valid;
    assign bus.o_last    = out_last;
    assign bus.o_data    = out_data;
    assign bus.o_channel = out_channel;
    assign bus.o_idle    = (state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sampler_mc.sv
// ============================================================================
// Module      : tb_sampler_mc
// Description : Directed self-checking bench for sampler_mc
//               (NUM_CH=2, DEPTH=4, DATA_SIZE=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sampler_mc;
    localparam int DS = 8;
    localparam int NC = 2;
    localparam int DP = 4;
    localparam int AS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] s0 [32];
    logic [7:0] s1 [32];
    logic [7:0] exp_d [8];

    always #5 clk = ~clk;

    sampler_mc_if #(.DATA_SIZE(DS), .NUM_CH(NC)) bus ();

    sampler_mc #(
        .DATA_SIZE(DS), .NUM_CH(NC), .DEPTH(DP), .ADDR_SIZE(AS), .DECIM_DEFAULT(4)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic d, input logic m, input logic [7:0] p);
        bus.i_cmd_decim = d;
        bus.i_cmd_mode  = m;
        bus.i_cmd_param = p;
        tick();
        bus.i_cmd_decim = 1'b0;
        bus.i_cmd_mode  = 1'b0;
        bus.i_cmd_param = 8'h00;
    endtask

    task automatic arm();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
    endtask

    task automatic gate_run(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_gate = 1'b1;
            bus.i_data = {s1[i], s0[i]};
            tick();
        end
        bus.i_gate = 1'b0;
        bus.i_data = '0;
        tick();
    endtask

    task automatic fill_ramp(input int n);
        for (int i = 0; i < n; i++) begin
            s0[i] = 8'(i + 1);
            s1[i] = 8'(8'h80 + i + 1);
        end
    endtask

    task automatic set_exp(input logic [63:0] v);
        for (int i = 0; i < 8; i++) exp_d[i] = v[63 - 8*i -: 8];
    endtask

    // Collects n samples; rnd=1 toggles i_ready randomly and checks stall
    // stability, rnd=0 holds i_ready high and checks no intra-frame bubble.
    task automatic drain_check(input int n, input int rnd, input string name);
        int         got;
        int         budget;
        int         last_acc;
        logic       held;
        logic       rdy;
        logic [7:0] hd;
        logic       hc;
        logic       hl;
        got = 0; budget = 0; last_acc = -10; held = 1'b0;
        hd = 8'h00; hc = 1'b0; hl = 1'b0;
        while (got < n && budget < 400) begin
            if (held) begin
                checks++;
                if (!(bus.o_valid === 1'b1 && bus.o_data === hd &&
                      bus.o_channel === hc && bus.o_last === hl)) begin
                    errors++;
                    $display("FAIL %s stall: got v=%b d=%h c=%b l=%b, need v=1 d=%h c=%b l=%b",
                             name, bus.o_valid, bus.o_data, bus.o_channel, bus.o_last, hd, hc, hl);
                end
            end
            rdy = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_ready = rdy;
            held = 1'b0;
            if (bus.o_valid === 1'b1) begin
                if (rdy) begin
                    checks++;
                    if (bus.o_data !== exp_d[got] || bus.o_channel !== 1'(got % 2) ||
                        bus.o_last !== (got == n - 1)) begin
                        errors++;
                        $display("FAIL %s sample %0d: got d=%h c=%b l=%b, need d=%h c=%b l=%b",
                                 name, got, bus.o_data, bus.o_channel, bus.o_last,
                                 exp_d[got], 1'(got % 2), (got == n - 1));
                    end
                    if (rnd == 0 && (got % 2) == 1) begin
                        checks++;
                        if (budget != last_acc + 1) begin
                            errors++;
                            $display("FAIL %s bubble at sample %0d: gap %0d cycles, need 1",
                                     name, got, budget - last_acc);
                        end
                    end
                    last_acc = budget;
                    got++;
                end else begin
                    held = 1'b1;
                    hd = bus.o_data; hc = bus.o_channel; hl = bus.o_last;
                end
            end
            tick();
            budget++;
        end
        bus.i_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s count: got %0d samples, need %0d", name, got, n);
        end
        checks++;
        if (bus.o_idle !== 1'b1 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end: got idle=%b valid=%b, need idle=1 valid=0",
                     name, bus.o_idle, bus.o_valid);
        end
    endtask

    task automatic test_reset();
        bus.i_enable = 1'b1; bus.i_start = 1'b0; bus.i_gate = 1'b0; bus.i_data = '0;
        bus.i_cmd_decim = 1'b0; bus.i_cmd_mode = 1'b0; bus.i_cmd_param = 8'h00;
        bus.i_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b need 0", bus.o_valid); end
        checks++;
        if (bus.o_idle !== 1'b1) begin errors++; $display("FAIL reset idle: got %b need 1", bus.o_idle); end
        checks++;
        if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset last: got %b need 0", bus.o_last); end
        checks++;
        if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset data: got %h need 00", bus.o_data); end
        checks++;
        if (bus.o_channel !== 1'b0) begin errors++; $display("FAIL reset channel: got %b need 0", bus.o_channel); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pick();
        send_cmd(1'b1, 1'b1, 8'd2);   // decim 2, pick (param[0]=0)
        fill_ramp(8);
        arm();
        gate_run(8);
        set_exp(64'h02_82_04_84_06_86_08_88);
        drain_check(8, 0, "pick");
    endtask

    task automatic test_peak();
        send_cmd(1'b1, 1'b1, 8'd3);   // decim 3, peak (param[0]=1)
        {s0[0], s0[1], s0[2], s0[3], s0[4], s0[5]} = {8'd5, 8'd9, 8'd2, 8'd1, 8'd1, 8'd7};
        {s0[6], s0[7], s0[8], s0[9], s0[10], s0[11]} = {8'hFF, 8'h7F, 8'h10, 8'h7F, 8'h80, 8'h00};
        {s1[0], s1[1], s1[2], s1[3], s1[4], s1[5]} = {8'h7F, 8'hFF, 8'h01, 8'h03, 8'h02, 8'h01};
        {s1[6], s1[7], s1[8], s1[9], s1[10], s1[11]} = {8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30};
        arm();
        gate_run(12);
        set_exp(64'h09_FF_07_03_FF_00_80_30);
        drain_check(8, 0, "peak");
    endtask

    task automatic test_gate_drop();
        send_cmd(1'b1, 1'b1, 8'd2);   // decim 2, pick
        for (int i = 0; i < 5; i++) begin s0[i] = 8'(8'h10 + i); s1[i] = 8'(8'h50 + i); end
        arm();
        gate_run(5);                  // 5th sample is a half window
        tick();
        for (int i = 0; i < 4; i++) begin s0[i] = 8'(8'h20 + i); s1[i] = 8'(8'h60 + i); end
        gate_run(4);
        set_exp(64'h11_51_13_53_21_61_23_63);
        drain_check(8, 0, "gate_drop");
    endtask

    task automatic test_back_to_back_random_ready();
        send_cmd(1'b1, 1'b1, 8'd2);
        fill_ramp(8);
        arm();
        gate_run(8);
        set_exp(64'h02_82_04_84_06_86_08_88);
        drain_check(8, 1, "rand_ready");
    endtask

    task automatic test_cmd_and_enable();
        send_cmd(1'b1, 1'b1, 8'd2);   // decim 2, pick
        for (int i = 0; i < 8; i++) begin
            s0[i] = (i % 2 == 0) ? 8'd9 : 8'd1;
            s1[i] = 8'(8'h30 + i + 1);
        end
        arm();
        for (int i = 0; i < 8; i++) begin
            bus.i_gate = 1'b1;
            bus.i_data = {s1[i], s0[i]};
            bus.i_cmd_decim = (i == 3);
            bus.i_cmd_mode  = (i == 3);
            bus.i_cmd_param = (i == 3) ? 8'h01 : 8'h00;
            tick();
        end
        bus.i_gate = 1'b0; bus.i_data = '0;
        bus.i_cmd_decim = 1'b0; bus.i_cmd_mode = 1'b0; bus.i_cmd_param = 8'h00;
        tick();
        set_exp(64'h01_32_01_34_01_36_01_38);
        drain_check(8, 0, "cmd_ignored");

        send_cmd(1'b1, 1'b0, 8'd0);   // decim 0 acts as 1
        for (int i = 0; i < 4; i++) begin s0[i] = 8'(8'hA1 + i); s1[i] = 8'(8'hB1 + i); end
        arm();
        gate_run(4);
        set_exp(64'hA1_B1_A2_B2_A3_B3_A4_B4);
        drain_check(8, 0, "decim0");

        send_cmd(1'b1, 1'b0, 8'd2);
        fill_ramp(8);
        arm();
        for (int i = 0; i < 3; i++) begin
            bus.i_gate = 1'b1; bus.i_data = {s1[i], s0[i]}; tick();
        end
        checks++;
        if (bus.o_idle !== 1'b0) begin errors++; $display("FAIL capture busy: got idle=%b need 0", bus.o_idle); end
        bus.i_enable = 1'b0;
        tick();
        checks++;
        if (bus.o_idle !== 1'b1 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_low: got idle=%b valid=%b need idle=1 valid=0", bus.o_idle, bus.o_valid);
        end
        bus.i_enable = 1'b1; bus.i_gate = 1'b0; bus.i_data = '0;
        tick();
        arm();
        gate_run(8);
        set_exp(64'h02_82_04_84_06_86_08_88);
        drain_check(8, 0, "after_enable");
    endtask

    task automatic test_reset_mid_drain();
        int w;
        send_cmd(1'b1, 1'b1, 8'd2);
        fill_ramp(8);
        arm();
        gate_run(8);
        w = 0;
        while (bus.o_valid !== 1'b1 && w < 20) begin tick(); w++; end
        checks++;
        if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL drain start: got valid=%b need 1", bus.o_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_idle !== 1'b1 || bus.o_last !== 1'b0) begin
            errors++;
            $display("FAIL async reset: got valid=%b idle=%b last=%b need 0 1 0",
                     bus.o_valid, bus.o_idle, bus.o_last);
        end
        tick();
        rst_n = 1'b1;
        tick();
        fill_ramp(16);
        arm();
        gate_run(16);                 // default decim 4 picks every 4th sample
        set_exp(64'h04_84_08_88_0C_8C_10_90);
        drain_check(8, 0, "decim_default");
    endtask

    initial begin
        test_reset();
        test_pick();
        test_peak();
        test_gate_drop();
        test_back_to_back_random_ready();
        test_cmd_and_enable();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
